sblock_cfg_loader: RTL and testbench
====================================

Name: sblock_cfg_loader

Overview:
- Configuration-side writer for the switch-block array: deserializes a 1-bit bitstream into addressed 18-bit frames and drives the shared bits bus plus one write-enable per Sblock.
- Sits between the bitstream source (pin or JTAG shim) and the Sblock config ports: bits_o fans out to every Sblock bits input, and wr_en_o[n] connects to Sblock n's wr_en.
- Frame format, MSB first: 8-bit block address, then 18 config bits (bit 17 first). Address 8'hFF is the terminator.

Parameters:
- NUM_BLOCKS, 4: number of Sblocks addressed; legal range 1..255.
- CFG_W, 18: config word width; must match the Sblock bits width.

Ports:
- clk_i  input  1  single clock
- rst_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  begin a load session; honoured only in IDLE or DONE
- cfg_valid_i  input  1  cfg_data_i carries a bitstream bit this cycle
- cfg_data_i  input  1  serial bitstream bit
- cfg_ready_o  output  1  loader accepts a bit this cycle; a bit transfers when cfg_valid_i && cfg_ready_o
- bits_o  output  CFG_W  config word broadcast to all Sblocks
- wr_en_o  output  NUM_BLOCKS  one-hot per-block write enable
- busy_o  output  1  session in progress
- done_o  output  1  session complete
- err_o  output  1  sticky: an out-of-range address was seen this session

Behaviour:
- Interface (already decided): one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset (asynchronous, takes effect immediately, including mid-session):
  - State goes to IDLE.
  - bits_o=0, wr_en_o=0, cfg_ready_o=0, busy_o=0, done_o=0, err_o=0.
  - Shift registers, bit counter and frame counter are cleared.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA, WRITE, DONE.
- IDLE / DONE:
  - cfg_ready_o=0; busy_o=0. done_o=1 in DONE only.
  - start_i=1 moves to ADDR at the next edge. That edge also clears done_o, err_o and the frame counter, and sets busy_o=1.
  - start_i is ignored in every other state.
- ADDR:
  - cfg_ready_o=1. Each transfer shifts one bit into the address register, MSB first.
  - No transfer (cfg_valid_i=0) means hold state; no bit is consumed.
  - At the 8th transfer: if the address is 8'hFF, go to DONE. Otherwise go to DATA.
- DATA:
  - cfg_ready_o=1. The 18 transfers shift in the config word, MSB first.
  - At the edge accepting the 18th bit, the next state is WRITE, and:
    - bits_o loads the full word (earlier bits plus the current bit);
    - if the address is below NUM_BLOCKS, wr_en_o gets a one-hot at that address;
    - otherwise wr_en_o stays 0 and err_o is set.
- WRITE:
  - Lasts exactly one cycle, with cfg_ready_o=0 and wr_en_o high for exactly this cycle.
  - At the next edge wr_en_o clears to 0.
  - If the address was in range, the frame counter increments.
  - If the count has reached NUM_BLOCKS, go to DONE. Otherwise go to ADDR.
- bits_o stability: bits_o is stable during the whole wr_en_o-high cycle. It holds its value until the next WRITE and never changes while any wr_en_o bit is high.
- Latency: wr_en_o rises one edge after the 18th data bit is accepted. Minimum frame time is 27 cycles (8 address + 18 data + 1 write).
- Duplicate address: the block is rewritten (the last write wins) and the frame counter still increments.
- Errored frames do not count toward NUM_BLOCKS.
- Frame counter width is clog2(NUM_BLOCKS+1). It never wraps, because reaching NUM_BLOCKS forces DONE.
- The terminator is honoured at any frame boundary, including before any write; no wr_en pulse is issued for it.
- A valid bit presented while cfg_ready_o=0 is not consumed; the source must hold it.

Test Plan:
- Reset, then start_i; frame addr=8'h02, data=18'b111000111111000111 with cfg_valid_i held high -> wr_en_o=4'b0100 for exactly 1 cycle, 27 cycles after the first bit is accepted; bits_o=18'h38FC7 during and after the pulse; busy_o=1.
- 4 frames to addresses 0,1,2,3 with data 18'h00001, 18'h00002, 18'h00004, 18'h00008 -> four single-cycle one-hot pulses with matching bits_o; DONE with done_o=1, busy_o=0 one cycle after the 4th WRITE.
- Frame addr=8'h07 (≥NUM_BLOCKS), then terminator 8'hFF -> no wr_en_o pulse; err_o=1 sticky; done_o=1. A new start_i clears err_o and done_o.
- cfg_valid_i toggled 1/0 every cycle through an addr-1 frame -> the same result as the back-to-back case, wr_en_o=4'b0010, with frame time stretched to 53 cycles.
- rst_n_i pulled low during the WRITE cycle -> wr_en_o=0 and bits_o=0 immediately, without waiting for a clock edge; after release the loader is in IDLE and stays there until start_i.
- start_i asserted mid-DATA -> ignored; the frame completes normally. Addr 1 written twice with 18'h3FFFF then 18'h00000 -> two pulses, final bits_o=0, frame counter counts 2.

Source files
------------

// File: rtl/sblock_cfg_loader.sv
// Switch-block configuration loader: deserializes a 1-bit bitstream into addressed
// config frames and drives a broadcast config word plus one write strobe per Sblock.
module sblock_cfg_loader #(
    parameter int NUM_BLOCKS = 4,
    parameter int CFG_W      = 18
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  cfg_valid_i,
    input  logic                  cfg_data_i,
    output logic                  cfg_ready_o,
    output logic [CFG_W-1:0]      bits_o,
    output logic [NUM_BLOCKS-1:0] wr_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int CNT_W = $clog2(NUM_BLOCKS + 1);
    localparam int BIT_W = $clog2((CFG_W > 8) ? CFG_W : 8);

    localparam logic [7:0]       TERM_ADDR = 8'hFF;
    localparam logic [8:0]       NB_ADDR   = 9'(NUM_BLOCKS);
    localparam logic [CNT_W-1:0] NB_CNT    = CNT_W'(NUM_BLOCKS);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(CFG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              addr_q, addr_d;
    logic [CFG_W-2:0]        shift_q, shift_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
    logic [CFG_W-1:0]        bits_q, bits_d;
    logic [NUM_BLOCKS-1:0]   wr_en_q, wr_en_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    xfer;
    logic [7:0]              addr_full;
    logic [CFG_W-1:0]        word_full;
    logic                    in_range;
    logic [CNT_W-1:0]        cnt_inc;

    assign xfer      = cfg_valid_i & ready_q;
    assign addr_full = {addr_q[6:0], cfg_data_i};
    assign word_full = {shift_q, cfg_data_i};
    assign in_range  = ({1'b0, addr_q} < NB_ADDR);
    assign cnt_inc   = frame_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        bits_d      = bits_q;
        wr_en_d     = '0;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_ADDR;
                    frame_cnt_d = '0;
                    bit_cnt_d   = '0;
                    err_d       = 1'b0;
                end
            end

            S_ADDR: begin
                if (xfer) begin
                    addr_d = addr_full;
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (addr_full == TERM_ADDR) ? S_DONE : S_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    shift_d = word_full[CFG_W-2:0];
                    if (bit_cnt_q == DATA_LAST) begin
                        // Word and strobe are registered together so bits_o is settled for the whole pulse
                        bit_cnt_d = '0;
                        bits_d    = word_full;
                        state_d   = S_WRITE;
                        if (in_range) begin
                            for (int i = 0; i < NUM_BLOCKS; i++) begin
                                wr_en_d[i] = (addr_q == 8'(i));
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (in_range) begin
                    frame_cnt_d = cnt_inc;
                    state_d     = (cnt_inc == NB_CNT) ? S_DONE : S_ADDR;
                end else begin
                    state_d = S_ADDR;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they register in step with it
        ready_d = (state_d == S_ADDR) || (state_d == S_DATA);
        busy_d  = (state_d == S_ADDR) || (state_d == S_DATA) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            bits_q      <= '0;
            wr_en_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            bits_q      <= bits_d;
            wr_en_q     <= wr_en_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign bits_o      = bits_q;
    assign wr_en_o     = wr_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Directed bench for sblock_cfg_loader: frame loading, strobes, errors, reset and restart handling.
module tb_sblock_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        cfg_valid_i;
    logic        cfg_data_i;
    logic        cfg_ready_o;
    logic [17:0] bits_o;
    logic [3:0]  wr_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sblock_cfg_loader #(.NUM_BLOCKS(4), .CFG_W(18)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .start_i    (start_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_data_i (cfg_data_i),
        .cfg_ready_o(cfg_ready_o),
        .bits_o     (bits_o),
        .wr_en_o    (wr_en_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_data_i  = 1'b0;
        step();
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Drives nbits_total frame bits (address MSB first, then data MSB first); returns
    // cycles spent up to and including the last accepted bit, and whether a strobe appeared early.
    task automatic drive_frame(input logic [7:0] addr, input logic [17:0] data,
                               input int nbits_total, input bit toggle, input bit mid_start,
                               output int cycles, output bit early_wr);
        int   nb;
        int   cyc;
        logic v;
        logic b;
        nb = 0;
        cyc = 0;
        early_wr = 1'b0;
        while (nb < nbits_total && cyc < 400) begin
            cyc++;
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            if (nb < 8) b = addr[7-nb];
            else        b = data[17-(nb-8)];
            cfg_valid_i = v;
            cfg_data_i  = b;
            start_i     = mid_start && (nb == 14);
            if (v && cfg_ready_o) nb++;
            step();
            if (nb < nbits_total && wr_en_o !== 4'b0000) early_wr = 1'b1;
        end
        cfg_valid_i = 1'b0;
        cfg_data_i  = 1'b0;
        start_i     = 1'b0;
        cycles = cyc;
    endtask

    task automatic test_reset();
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_data_i  = 1'b0;
        step();
        step();
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0000", wr_en_o); end
        n_checks++; if (bits_o !== 18'h00000) begin n_fail++; $display("FAIL reset_bits: got %h expected 00000", bits_o); end
        n_checks++; if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cfg_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int cyc;
        bit early;
        do_reset();
        pulse_start();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", busy_o); end
        n_checks++; if (cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL start_ready: got %b expected 1", cfg_ready_o); end
        drive_frame(8'h02, 18'b111000111111000111, 26, 1'b0, 1'b0, cyc, early);
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL single_early_wr: got %b expected 0", early); end
        n_checks++; if (cyc + 1 != 27) begin n_fail++; $display("FAIL single_latency: got %0d expected 27", cyc + 1); end
        n_checks++; if (wr_en_o !== 4'b0100) begin n_fail++; $display("FAIL single_wr_en: got %b expected 0100", wr_en_o); end
        n_checks++; if (bits_o !== 18'h38FC7) begin n_fail++; $display("FAIL single_bits: got %h expected 38fc7", bits_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy_o); end
        n_checks++; if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_write_ready: got %b expected 0", cfg_ready_o); end
        step();
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL single_wr_clear: got %b expected 0000", wr_en_o); end
        n_checks++; if (bits_o !== 18'h38FC7) begin n_fail++; $display("FAIL single_bits_hold: got %h expected 38fc7", bits_o); end
        n_checks++; if (cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_next_ready: got %b expected 1", cfg_ready_o); end
    endtask

    task automatic test_four_frames();
        int          cyc;
        bit          early;
        logic [3:0]  exp_wr;
        logic [17:0] exp_d;
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            exp_wr = 4'b0001 << i;
            exp_d  = 18'd1 << i;
            drive_frame(8'(i), exp_d, 26, 1'b0, 1'b0, cyc, early);
            n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL four_early_wr[%0d]: got %b expected 0", i, early); end
            n_checks++; if (wr_en_o !== exp_wr) begin n_fail++; $display("FAIL four_wr_en[%0d]: got %b expected %b", i, wr_en_o, exp_wr); end
            n_checks++; if (bits_o !== exp_d) begin n_fail++; $display("FAIL four_bits[%0d]: got %h expected %h", i, bits_o, exp_d); end
        end
        step();
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL four_done: got %b expected 1", done_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL four_busy: got %b expected 0", busy_o); end
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL four_wr_clear: got %b expected 0000", wr_en_o); end
        n_checks++; if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL four_done_ready: got %b expected 0", cfg_ready_o); end
        n_checks++; if (bits_o !== 18'h00008) begin n_fail++; $display("FAIL four_bits_hold: got %h expected 00008", bits_o); end
    endtask

    task automatic test_err_terminator();
        int cyc;
        bit early;
        do_reset();
        pulse_start();
        drive_frame(8'h07, 18'h15555, 26, 1'b0, 1'b0, cyc, early);
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL err_no_wr: got %b expected 0000", wr_en_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err_o); end
        step();
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_o); end
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL err_no_wr_late: got %b expected 0000", wr_en_o); end
        drive_frame(8'hFF, 18'h00000, 8, 1'b0, 1'b0, cyc, early);
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL term_early_wr: got %b expected 0", early); end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL term_done: got %b expected 1", done_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL term_busy: got %b expected 0", busy_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL term_err_kept: got %b expected 1", err_o); end
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL term_wr: got %b expected 0000", wr_en_o); end
        pulse_start();
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL restart_err: got %b expected 0", err_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b expected 0", done_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b expected 1", busy_o); end
    endtask

    task automatic test_toggle_valid();
        int cyc;
        bit early;
        do_reset();
        pulse_start();
        drive_frame(8'h01, 18'h2AAAA, 26, 1'b1, 1'b0, cyc, early);
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL toggle_early_wr: got %b expected 0", early); end
        n_checks++; if (cyc + 1 != 53) begin n_fail++; $display("FAIL toggle_latency: got %0d expected 53", cyc + 1); end
        n_checks++; if (wr_en_o !== 4'b0010) begin n_fail++; $display("FAIL toggle_wr_en: got %b expected 0010", wr_en_o); end
        n_checks++; if (bits_o !== 18'h2AAAA) begin n_fail++; $display("FAIL toggle_bits: got %h expected 2aaaa", bits_o); end
        step();
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL toggle_wr_clear: got %b expected 0000", wr_en_o); end
    endtask

    task automatic test_reset_in_write();
        int cyc;
        bit early;
        do_reset();
        pulse_start();
        drive_frame(8'h03, 18'h3FFFF, 26, 1'b0, 1'b0, cyc, early);
        n_checks++; if (wr_en_o !== 4'b1000) begin n_fail++; $display("FAIL rstw_pre_wr: got %b expected 1000", wr_en_o); end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++; if (wr_en_o !== 4'b0000) begin n_fail++; $display("FAIL rstw_async_wr: got %b expected 0000", wr_en_o); end
        n_checks++; if (bits_o !== 18'h00000) begin n_fail++; $display("FAIL rstw_async_bits: got %h expected 00000", bits_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstw_async_busy: got %b expected 0", busy_o); end
        @(negedge clk);
        rst_n_i     = 1'b1;
        cfg_valid_i = 1'b1;
        repeat (3) step();
        cfg_valid_i = 1'b0;
        n_checks++; if (cfg_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstw_idle_ready: got %b expected 0", cfg_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstw_idle_busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rstw_idle_done: got %b expected 0", done_o); end
        pulse_start();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rstw_start_busy: got %b expected 1", busy_o); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit early;
        do_reset();
        pulse_start();
        drive_frame(8'h01, 18'h3FFFF, 26, 1'b0, 1'b1, cyc, early);
        n_checks++; if (cyc + 1 != 27) begin n_fail++; $display("FAIL midstart_latency: got %0d expected 27", cyc + 1); end
        n_checks++; if (wr_en_o !== 4'b0010) begin n_fail++; $display("FAIL midstart_wr_en: got %b expected 0010", wr_en_o); end
        n_checks++; if (bits_o !== 18'h3FFFF) begin n_fail++; $display("FAIL midstart_bits: got %h expected 3ffff", bits_o); end
        drive_frame(8'h01, 18'h00000, 26, 1'b0, 1'b0, cyc, early);
        n_checks++; if (wr_en_o !== 4'b0010) begin n_fail++; $display("FAIL dup_wr_en: got %b expected 0010", wr_en_o); end
        n_checks++; if (bits_o !== 18'h00000) begin n_fail++; $display("FAIL dup_bits: got %h expected 00000", bits_o); end
        drive_frame(8'h03, 18'h12345, 26, 1'b0, 1'b0, cyc, early);
        n_checks++; if (wr_en_o !== 4'b1000) begin n_fail++; $display("FAIL dup3_wr_en: got %b expected 1000", wr_en_o); end
        step();
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL dup3_not_done: got %b expected 0", done_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL dup3_busy: got %b expected 1", busy_o); end
        drive_frame(8'h00, 18'h00F0F, 26, 1'b0, 1'b0, cyc, early);
        n_checks++; if (wr_en_o !== 4'b0001) begin n_fail++; $display("FAIL dup4_wr_en: got %b expected 0001", wr_en_o); end
        step();
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL dup4_done: got %b expected 1", done_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dup4_busy: got %b expected 0", busy_o); end
        n_checks++; if (bits_o !== 18'h00F0F) begin n_fail++; $display("FAIL dup4_bits: got %h expected 00f0f", bits_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_four_frames();
        test_err_terminator();
        test_toggle_valid();
        test_reset_in_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
